// File: rtl/router_vc_link_buffer.sv
// Per-link router input stage: one FIFO per virtual channel, packet-lock tracking,
// and a round-robin arbiter that forwards one flit per cycle to a registered output.
module router_vc_link_buffer #(
  parameter int unsigned DATA_W = 35,
  parameter int unsigned NUM_VC = 2,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned VC_W   = $clog2(NUM_VC)
) (
  input  logic              clk,
  input  logic              RST_,
  input  logic [DATA_W-1:0] IDATA,
  input  logic              IVALID,
  input  logic [VC_W-1:0]   IVCH,
  output logic [NUM_VC-1:0] OACK,
  output logic [NUM_VC-1:0] ORDY,
  output logic [NUM_VC-1:0] OLCK,
  output logic              OERR,
  output logic [DATA_W-1:0] ODATA,
  output logic              OVALID,
  output logic [VC_W-1:0]   OVCH,
  input  logic [NUM_VC-1:0] IRDY
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  localparam logic [1:0] FT_BODY   = 2'b00;
  localparam logic [1:0] FT_HEAD   = 2'b01;
  localparam logic [1:0] FT_TAIL   = 2'b10;
  localparam logic [1:0] FT_SINGLE = 2'b11;

  logic [DATA_W-1:0] mem_q [NUM_VC][DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q [NUM_VC];
  logic [PTR_W-1:0]  wr_ptr_d [NUM_VC];
  logic [PTR_W-1:0]  rd_ptr_q [NUM_VC];
  logic [PTR_W-1:0]  rd_ptr_d [NUM_VC];
  logic [CNT_W-1:0]  cnt_q    [NUM_VC];
  logic [CNT_W-1:0]  cnt_d    [NUM_VC];

  logic [VC_W-1:0]   rr_q, rr_d;
  logic [NUM_VC-1:0] lck_q, lck_d;
  logic [NUM_VC-1:0] ack_q, ack_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] odata_q, odata_d;
  logic              ovalid_q, ovalid_d;
  logic [VC_W-1:0]   ovch_q, ovch_d;

  logic [NUM_VC-1:0] ordy_c, vc_hit, elig, push, pop;
  logic              wr_ok, drop, proto_err;
  logic              gnt_vld;
  logic [VC_W-1:0]   gnt_vc, cand;
  logic [1:0]        ftype;

  // Per-VC status decode from registered counts.
  always_comb begin
    ordy_c = '0;
    vc_hit = '0;
    elig   = '0;
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      ordy_c[v] = (cnt_q[v] < CNT_W'(DEPTH));
      vc_hit[v] = (IVCH == VC_W'(v));
      elig[v]   = (cnt_q[v] != '0) && IRDY[v];
    end
  end

  // Out-of-range VC leaves vc_hit empty, so the flit falls into the drop path.
  assign wr_ok = IVALID && |(vc_hit & ordy_c);
  assign push  = wr_ok ? vc_hit : '0;
  assign drop  = IVALID && !wr_ok;
  assign ftype = IDATA[DATA_W-1 -: 2];

  // Round-robin search starting one past the last granted VC.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_vc  = '0;
    cand    = '0;
    for (int unsigned k = 1; k <= NUM_VC; k++) begin
      cand = VC_W'((32'(rr_q) + k) % NUM_VC);
      if (!gnt_vld && elig[cand]) begin
        gnt_vld = 1'b1;
        gnt_vc  = cand;
      end
    end
  end

  always_comb begin
    pop = '0;
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      pop[v] = gnt_vld && (gnt_vc == VC_W'(v));
    end
  end

  // Next-state: FIFO bookkeeping, lock tracking, error, output stage.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    lck_d     = lck_q;
    rr_d      = rr_q;
    odata_d   = odata_q;
    ovch_d    = ovch_q;
    ovalid_d  = 1'b0;
    ack_d     = push;
    proto_err = 1'b0;

    for (int unsigned v = 0; v < NUM_VC; v++) begin
      if (push[v]) begin
        wr_ptr_d[v] = wr_ptr_q[v] + PTR_W'(1);
        unique case (ftype)
          FT_HEAD: begin
            if (lck_q[v]) proto_err = 1'b1;
            lck_d[v] = 1'b1;
          end
          FT_TAIL: begin
            if (!lck_q[v]) proto_err = 1'b1;
            lck_d[v] = 1'b0;
          end
          FT_BODY:   if (!lck_q[v]) proto_err = 1'b1;
          FT_SINGLE: if (lck_q[v]) proto_err = 1'b1;
          default: ;
        endcase
      end
      if (pop[v]) rd_ptr_d[v] = rd_ptr_q[v] + PTR_W'(1);
      unique case ({push[v], pop[v]})
        2'b10:   cnt_d[v] = cnt_q[v] + CNT_W'(1);
        2'b01:   cnt_d[v] = cnt_q[v] - CNT_W'(1);
        default: cnt_d[v] = cnt_q[v];
      endcase
    end

    err_d = err_q | drop | proto_err;

    if (gnt_vld) begin
      ovalid_d = 1'b1;
      ovch_d   = gnt_vc;
      odata_d  = mem_q[gnt_vc][rd_ptr_q[gnt_vc]];
      rr_d     = gnt_vc;
    end
  end

  always_ff @(posedge clk or negedge RST_) begin
    if (!RST_) begin
      for (int unsigned v = 0; v < NUM_VC; v++) begin
        wr_ptr_q[v] <= '0;
        rd_ptr_q[v] <= '0;
        cnt_q[v]    <= '0;
      end
      rr_q     <= VC_W'(NUM_VC - 1);
      lck_q    <= '0;
      ack_q    <= '0;
      err_q    <= 1'b0;
      odata_q  <= '0;
      ovalid_q <= 1'b0;
      ovch_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      rr_q     <= rr_d;
      lck_q    <= lck_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      odata_q  <= odata_d;
      ovalid_q <= ovalid_d;
      ovch_q   <= ovch_d;
    end
  end

  // Storage needs no reset: only slots covered by a non-zero count are ever read.
  always_ff @(posedge clk) begin
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      if (push[v]) mem_q[v][wr_ptr_q[v]] <= IDATA;
    end
  end

  assign OACK   = ack_q;
  assign ORDY   = ordy_c;
  assign OLCK   = lck_q;
  assign OERR   = err_q;
  assign ODATA  = odata_q;
  assign OVALID = ovalid_q;
  assign OVCH   = ovch_q;

endmodule

// File: tb/tb_router_vc_link_buffer.sv
// Bench for router_vc_link_buffer: directed scenarios plus random traffic, all checked
// every cycle against a queue-based reference model.
module tb_router_vc_link_buffer;

  localparam int unsigned DATA_W = 35;
  localparam int unsigned NUM_VC = 2;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned VC_W   = 1;

  logic              clk = 1'b0;
  logic              RST_;
  logic [DATA_W-1:0] IDATA;
  logic              IVALID;
  logic [VC_W-1:0]   IVCH;
  logic [NUM_VC-1:0] IRDY;
  logic [NUM_VC-1:0] OACK, ORDY, OLCK;
  logic              OERR, OVALID;
  logic [DATA_W-1:0] ODATA;
  logic [VC_W-1:0]   OVCH;

  always #5 clk = ~clk;

  router_vc_link_buffer #(
    .DATA_W(DATA_W), .NUM_VC(NUM_VC), .DEPTH(DEPTH), .VC_W(VC_W)
  ) dut (
    .clk(clk), .RST_(RST_), .IDATA(IDATA), .IVALID(IVALID), .IVCH(IVCH),
    .OACK(OACK), .ORDY(ORDY), .OLCK(OLCK), .OERR(OERR), .ODATA(ODATA),
    .OVALID(OVALID), .OVCH(OVCH), .IRDY(IRDY)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state
  logic [DATA_W-1:0] mq [NUM_VC][$];
  int                m_rr;
  logic [NUM_VC-1:0] m_lck, m_ack;
  logic              m_err, m_ovalid;
  logic [DATA_W-1:0] m_odata;
  logic [VC_W-1:0]   m_ovch;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] mk(input logic [1:0] ft, input logic [32:0] pl);
    return {ft, pl};
  endfunction

  task automatic model_reset();
    for (int v = 0; v < NUM_VC; v++) mq[v].delete();
    m_rr     = NUM_VC - 1;
    m_lck    = '0;
    m_ack    = '0;
    m_err    = 1'b0;
    m_ovalid = 1'b0;
    m_odata  = '0;
    m_ovch   = '0;
  endtask

  // One clock edge of the specified behaviour, using pre-edge queue contents.
  task automatic model_step();
    int g = -1;
    int ch = int'(IVCH);
    logic [1:0] ft = IDATA[DATA_W-1 -: 2];
    bit full;
    for (int k = 1; k <= NUM_VC; k++) begin
      int v = (m_rr + k) % NUM_VC;
      if (g < 0 && mq[v].size() > 0 && IRDY[v]) g = v;
    end
    full  = (ch < NUM_VC) ? (mq[ch].size() >= DEPTH) : 1'b1;
    m_ack = '0;
    if (g >= 0) begin
      m_odata  = mq[g].pop_front();
      m_ovch   = VC_W'(g);
      m_ovalid = 1'b1;
      m_rr     = g;
    end else begin
      m_ovalid = 1'b0;
    end
    if (IVALID) begin
      if (full) begin
        m_err = 1'b1;
      end else begin
        mq[ch].push_back(IDATA);
        m_ack[ch] = 1'b1;
        if ((ft == 2'b01 || ft == 2'b11) && m_lck[ch]) m_err = 1'b1;
        if ((ft == 2'b00 || ft == 2'b10) && !m_lck[ch]) m_err = 1'b1;
        if (ft == 2'b01) m_lck[ch] = 1'b1;
        if (ft == 2'b10) m_lck[ch] = 1'b0;
      end
    end
  endtask

  task automatic compare_all();
    logic [NUM_VC-1:0] exp_rdy;
    for (int v = 0; v < NUM_VC; v++) exp_rdy[v] = (mq[v].size() < DEPTH);
    check_eq("oack",   64'(OACK),   64'(m_ack));
    check_eq("ordy",   64'(ORDY),   64'(exp_rdy));
    check_eq("olck",   64'(OLCK),   64'(m_lck));
    check_eq("oerr",   64'(OERR),   64'(m_err));
    check_eq("ovalid", 64'(OVALID), 64'(m_ovalid));
    check_eq("ovch",   64'(OVCH),   64'(m_ovch));
    check_eq("odata",  64'(ODATA),  64'(m_odata));
  endtask

  task automatic cycle(input logic v, input logic [VC_W-1:0] ch,
                       input logic [DATA_W-1:0] d, input logic [NUM_VC-1:0] rdy);
    IVALID = v;
    IVCH   = ch;
    IDATA  = d;
    IRDY   = rdy;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle(input int n, input logic [NUM_VC-1:0] rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, rdy);
  endtask

  // Reset asserted between edges; outputs must clear without waiting for a clock.
  task automatic do_reset();
    @(negedge clk);
    #2;
    RST_   = 1'b0;
    IVALID = 1'b0;
    #1;
    model_reset();
    compare_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    RST_ = 1'b1;
  endtask

  initial begin
    RST_   = 1'b1;
    IVALID = 1'b0;
    IVCH   = '0;
    IDATA  = '0;
    IRDY   = '0;
    model_reset();
    #7;
    do_reset();

    // Single flit: ACK after one edge, output one edge later
    cycle(1'b1, 1'b0, mk(2'b11, 33'h1234), 2'b11);
    check_eq("p1_ack", 64'(OACK), 64'h1);
    idle(1, 2'b11);
    check_eq("p1_valid", 64'(OVALID), 64'h1);
    check_eq("p1_data", 64'(ODATA[15:0]), 64'h1234);
    check_eq("p1_err", 64'(OERR), 64'h0);
    idle(2, 2'b11);

    // Fill VC1, overflow, then drain in order
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, mk(2'b11, 33'(8'hA0 + i)), 2'b00);
    check_eq("p2_ordy_full", 64'(ORDY), 64'h1);
    cycle(1'b1, 1'b1, mk(2'b11, 33'hBAD), 2'b00);
    check_eq("p2_drop_ack", 64'(OACK), 64'h0);
    check_eq("p2_drop_err", 64'(OERR), 64'h1);
    for (int i = 0; i < 4; i++) begin
      idle(1, 2'b10);
      check_eq("p2_drain", 64'(ODATA[7:0]), 64'(8'hA0 + i));
    end
    idle(2, 2'b10);

    // Round-robin interleave
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, mk(2'b11, 33'(i)), 2'b00);
      cycle(1'b1, 1'b1, mk(2'b11, 33'(16 + i)), 2'b00);
    end
    for (int i = 0; i < 6; i++) begin
      idle(1, 2'b11);
      check_eq("p3_rr_vch", 64'(OVCH), 64'(i % 2));
      check_eq("p3_rr_vld", 64'(OVALID), 64'h1);
    end
    idle(1, 2'b11);

    // Packet lock on VC0
    do_reset();
    cycle(1'b1, 1'b0, mk(2'b01, 33'h1), 2'b11);
    check_eq("p4_lck_head", 64'(OLCK), 64'h1);
    cycle(1'b1, 1'b0, mk(2'b00, 33'h2), 2'b11);
    check_eq("p4_lck_body", 64'(OLCK), 64'h1);
    cycle(1'b1, 1'b0, mk(2'b10, 33'h3), 2'b11);
    check_eq("p4_lck_tail", 64'(OLCK), 64'h0);
    check_eq("p4_noerr", 64'(OERR), 64'h0);
    cycle(1'b1, 1'b0, mk(2'b00, 33'h4), 2'b11);
    check_eq("p4_orphan_err", 64'(OERR), 64'h1);
    idle(3, 2'b11);

    // Full VC0 with a write on the same edge as a pop
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, mk(2'b11, 33'(i)), 2'b00);
    cycle(1'b1, 1'b0, mk(2'b11, 33'h77), 2'b01);
    check_eq("p5_err", 64'(OERR), 64'h1);
    check_eq("p5_ack", 64'(OACK), 64'h0);
    check_eq("p5_ordy", 64'(ORDY[0]), 64'h1);
    idle(4, 2'b01);

    // Reset mid-packet with both VCs holding flits
    do_reset();
    cycle(1'b1, 1'b0, mk(2'b01, 33'h10), 2'b00);
    cycle(1'b1, 1'b1, mk(2'b01, 33'h20), 2'b00);
    cycle(1'b1, 1'b0, mk(2'b00, 33'h11), 2'b00);
    check_eq("p6_lck", 64'(OLCK), 64'h3);
    do_reset();
    check_eq("p6_ordy", 64'(ORDY), 64'h3);
    for (int i = 0; i < 4; i++) begin
      idle(1, 2'b11);
      check_eq("p6_no_stale", 64'(OVALID), 64'h0);
    end

    // Random traffic in a few reset-separated segments
    for (int s = 0; s < 3; s++) begin
      do_reset();
      for (int i = 0; i < 250; i++) begin
        cycle(($urandom_range(0, 3) != 0), VC_W'($urandom_range(0, 1)),
              DATA_W'({$urandom(), $urandom()}), NUM_VC'($urandom_range(0, 3)));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/router_vc_link_buffer.md
Name: router_vc_link_buffer

Overview:
- Parametrised per-link input stage for the mesh router.
- Buffers incoming flits in one FIFO per virtual channel (VC) and tracks packet lock per VC using head/tail flit type.
- Forwards one flit per cycle to a registered output, using round-robin arbitration among VCs that are non-empty and downstream-ready.
- One instance sits between each router input link and the crossbar.

Parameters:
- DATA_W, 35, flit width. Bits [DATA_W-1:DATA_W-2] are the flit type: 01 head, 00 body, 10 tail, 11 single (head+tail).
- NUM_VC, 2, number of virtual channels. Must be ≥2.
- DEPTH, 4, flits per VC FIFO. Must be a power of 2, ≥2.
- VC_W, $clog2(NUM_VC), width of the VC index.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- RST_  in  1  reset, asynchronous, active-low.
- IDATA  in  DATA_W  incoming flit.
- IVALID  in  1  IDATA/IVCH valid this cycle.
- IVCH  in  VC_W  VC of incoming flit.
- OACK  out  NUM_VC  registered one-cycle pulse; bit v = flit for VC v was written.
- ORDY  out  NUM_VC  bit v = VC v FIFO not full (count < DEPTH), decoded from registered count.
- OLCK  out  NUM_VC  registered; bit v = VC v is mid-packet (head accepted, tail not yet accepted).
- OERR  out  1  registered sticky error flag.
- ODATA  out  DATA_W  registered outgoing flit.
- OVALID  out  1  registered; ODATA valid for exactly this cycle.
- OVCH  out  VC_W  registered VC of ODATA.
- IRDY  in  NUM_VC  downstream can take a flit on VC v this cycle.

Behaviour:
- Reset (RST_=0, asynchronous):
  - All FIFO counts and pointers cleared; ODATA/OVALID/OVCH/OACK/OLCK/OERR = 0.
  - ORDY = all ones (counts are 0).
  - Round-robin pointer = NUM_VC-1, so VC0 has first priority.
  - Reset mid-packet discards all buffered flits and locks.
  - No output toggles until the first edge after RST_ rises.
- Write rule: at an edge with IVALID=1, IVCH<NUM_VC and ORDY[IVCH]=1:
  - Push IDATA into FIFO[IVCH].
  - OACK[IVCH]=1 for the next cycle; all other OACK bits 0.
- Drop rule: IVALID=1 with ORDY[IVCH]=0, or IVCH≥NUM_VC:
  - Flit dropped, no OACK.
  - OERR set to 1 and held until reset.
- Full boundary: ORDY reflects count before the edge. A write to a full FIFO is dropped even if the same edge pops that FIFO.
- Lock tracking (on accepted write):
  - Head type: OLCK[v] set.
  - Tail type: OLCK[v] cleared.
  - Single type: OLCK[v] unchanged (must already be 0).
  - Protocol errors set OERR; the flit is still written:
    - head or single while OLCK[v]=1;
    - body or tail while OLCK[v]=0.
- Arbitration (combinational each cycle):
  - Eligible VCs: FIFO[v] non-empty and IRDY[v]=1.
  - Grant the first eligible VC searching from pointer+1 upward, wrapping modulo NUM_VC.
  - On a grant at an edge: pop FIFO[g]; ODATA<=head flit; OVCH<=g; OVALID<=1; pointer<=g.
  - No eligible VC: OVALID<=0; ODATA/OVCH hold; pointer holds.
- VC interleaving: arbitration is per flit, so flits of different VCs may interleave on the output. Order within a VC is strict FIFO.
- Latency:
  - A flit written at edge E0 is eligible in the cycle after E0, so OVALID rises no earlier than edge E1 (1-cycle minimum).
  - No bypass of an empty FIFO.
- Simultaneous push and pop on the same VC: count unchanged; both pointers advance modulo DEPTH.
- Throughput: one flit per cycle sustained.
- Downstream contract:
  - Outputs are credit-like: the downstream must capture every OVALID flit.
  - IRDY is sampled only in the cycle of selection.

Test Plan:
- Reset then single flit: IVALID=1, IVCH=0, type 11, payload 0x1234 → OACK=01 next cycle; OVALID=1, OVCH=0, ODATA payload 0x1234 one cycle later; OLCK stays 00; OERR=0.
- Fill VC1 with DEPTH=4, IRDY=00: 4 flits accepted, ORDY=01 after the 4th. 5th flit dropped, no OACK, OERR=1. Raise IRDY=10 → 4 flits out in order on consecutive cycles, OVCH=1.
- Round-robin: preload 3 flits on each of VC0 and VC1, IRDY=11 → OVCH sequence 0,1,0,1,0,1 with OVALID continuously high.
- Packet lock: on VC0 send head, body, tail → OLCK[0]=1 after head, still 1 after body, 0 after tail. Then a body on VC0 with no open packet → OERR=1.
- Full plus simultaneous pop: VC0 full, IRDY[0]=1, write to VC0 at the same edge → write dropped, OERR=1, count goes 4→3, ORDY[0]=1 next cycle.
- Async reset mid-packet: assert RST_=0 between clock edges while both FIFOs hold flits and OLCK=11 → all outputs 0 and ORDY=11 immediately. After release, no stale flit appears on ODATA.
